// File: rtl/pwm_dac_out.sv
// PWM DAC output stage: buffers 8-bit samples and emits one fixed-length PWM period per sample.
// Define PWM_DAC_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise a single holding register is used.
module pwm_dac_out #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             enable,
  input  logic             clear_underrun,
  output logic             pwm_out,
  output logic             period_start,
  output logic             underrun
);

`ifdef PWM_DAC_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  // The holding-register build is simply a one-entry buffer.
  localparam int BUF_DEPTH = FIFO_EN ? FIFO_DEPTH : 1;
  localparam int IW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW        = $clog2(BUF_DEPTH + 1);
  localparam int PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [IW-1:0]    IDX_LAST = IW'(BUF_DEPTH - 1);
  localparam logic [CW-1:0]    FILL_MAX = CW'(BUF_DEPTH);

  logic [WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [IW-1:0]    r_wr_idx;
  logic [IW-1:0]    r_rd_idx;
  logic [CW-1:0]    r_fill;

  logic             r_en;
  logic [PW-1:0]    r_pre;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_duty;
  logic             r_pwm;
  logic             r_pstart;
  logic             r_underrun;

  logic             w_full;
  logic             w_nonempty;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;
  logic             w_run;
  logic             w_tick;
  logic             w_boundary;
  logic [PW-1:0]    w_pre_next;
  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_duty_next;
  logic             w_pwm_next;
  logic             w_pstart_next;
  logic             w_underrun_next;

  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] idx);
    return (idx == IDX_LAST) ? '0 : idx + IW'(1);
  endfunction

  // ---------------- sample buffer ----------------
  assign w_full       = (r_fill == FILL_MAX);
  assign w_nonempty   = (r_fill != '0);
  assign w_push       = sample_valid && !w_full;
  assign w_pop        = w_boundary && w_nonempty;
  assign w_head       = r_mem[r_rd_idx];
  assign sample_ready = !w_full;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_idx] <= sample_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) begin
        r_wr_idx <= idx_inc(r_wr_idx);
      end
      if (w_pop) begin
        r_rd_idx <= idx_inc(r_rd_idx);
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + CW'(1);
        2'b01:   r_fill <= r_fill - CW'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  // ---------------- period timing ----------------
  // Counters only advance once enable has been high for a full cycle, so the
  // first enabled cycle always shows cnt = 0 and a period_start pulse.
  assign w_run      = enable && r_en;
  assign w_tick     = w_run && (r_pre == PRE_LAST);
  assign w_boundary = w_tick && (r_cnt == CNT_LAST);

  always_comb begin
    w_pre_next      = '0;
    w_cnt_next      = '0;
    w_duty_next     = r_duty;
    w_underrun_next = r_underrun;
    if (w_run) begin
      w_pre_next = w_tick ? '0 : r_pre + PW'(1);
      if (w_boundary) begin
        w_cnt_next = '0;
      end else if (w_tick) begin
        w_cnt_next = r_cnt + WIDTH'(1);
      end else begin
        w_cnt_next = r_cnt;
      end
    end
    if (w_pop) begin
      w_duty_next = w_head;
    end
    if (w_boundary && !w_nonempty) begin
      w_underrun_next = 1'b1;
    end else if (clear_underrun) begin
      w_underrun_next = 1'b0;
    end
    // Outputs are computed from next-state values so they line up with cnt.
    w_pwm_next    = enable && (w_cnt_next < w_duty_next);
    w_pstart_next = enable && (w_pre_next == '0) && (w_cnt_next == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en       <= 1'b0;
      r_pre      <= '0;
      r_cnt      <= '0;
      r_duty     <= '0;
      r_pwm      <= 1'b0;
      r_pstart   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_en       <= enable;
      r_pre      <= w_pre_next;
      r_cnt      <= w_cnt_next;
      r_duty     <= w_duty_next;
      r_pwm      <= w_pwm_next;
      r_pstart   <= w_pstart_next;
      r_underrun <= w_underrun_next;
    end
  end

  assign pwm_out      = r_pwm;
  assign period_start = r_pstart;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_pwm_dac_out.sv
// Directed bench for pwm_dac_out: one instance at PRESCALE=1 and one at PRESCALE=3.
module tb_pwm_dac_out;

  localparam int TB_DEPTH = 4;
`ifdef PWM_DAC_FIFO_EN
  localparam int EXP_FILL     = TB_DEPTH;
  localparam int EXP_RDY_ONE  = 1;
`else
  localparam int EXP_FILL     = 1;
  localparam int EXP_RDY_ONE  = 0;
`endif

  typedef struct {
    logic [7:0] sample;
    int         exp_high;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n = 1'b0, b_rst_n = 1'b0;
  logic [7:0] a_sample_in = '0, b_sample_in = '0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic       a_ready, b_ready;
  logic       a_enable = 1'b0, b_enable = 1'b0;
  logic       a_clear = 1'b0, b_clear = 1'b0;
  logic       a_pwm, b_pwm, a_ps, b_ps, a_ur, b_ur;

  int n_vec = 0;
  int n_bad = 0;
  int a_acc_cnt = 0;
  bit stream_on = 1'b0;
  logic [7:0] stream_data = '0;

  pwm_dac_out #(.WIDTH(8), .PRESCALE(1), .FIFO_DEPTH(TB_DEPTH)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .sample_in(a_sample_in), .sample_valid(a_valid),
    .sample_ready(a_ready), .enable(a_enable), .clear_underrun(a_clear),
    .pwm_out(a_pwm), .period_start(a_ps), .underrun(a_ur)
  );

  pwm_dac_out #(.WIDTH(8), .PRESCALE(3), .FIFO_DEPTH(TB_DEPTH)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .sample_in(b_sample_in), .sample_valid(b_valid),
    .sample_ready(b_ready), .enable(b_enable), .clear_underrun(b_clear),
    .pwm_out(b_pwm), .period_start(b_ps), .underrun(b_ur)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock; tracks handshakes on instance A and feeds the streaming source.
  task automatic tick();
    bit acc;
    acc = a_valid && a_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      a_acc_cnt++;
      if (stream_on) begin
        stream_data = stream_data + 8'd1;
        a_sample_in = stream_data;
      end
    end
  endtask

  // Runs one period (the first tick enters it) and checks its waveform.
  task automatic measure(input bit sel, input int len, input int exp_high, input bit push_en,
                         input logic [7:0] push_val, input int exp_ur, input string tag);
    int high = 0;
    int starts = 0;
    int bad_shape = 0;
    logic pwm, ps, ur;
    for (int j = 0; j < len; j++) begin
      tick();
      pwm = sel ? b_pwm : a_pwm;
      ps  = sel ? b_ps  : a_ps;
      ur  = sel ? b_ur  : a_ur;
      if (j == 0) begin
        check({tag, " period_start@0"}, int'(ps), 1);
        if (exp_ur >= 0) check({tag, " underrun@0"}, int'(ur), exp_ur);
        if (push_en) begin
          a_sample_in = push_val;
          a_valid = 1'b1;
        end
      end
      if (j == 1 && push_en) a_valid = 1'b0;
      if (pwm) high++;
      if (ps) starts++;
      if (pwm != (j < exp_high)) bad_shape++;
    end
    check({tag, " high clocks"}, high, exp_high);
    check({tag, " period_start count"}, starts, 1);
    check({tag, " shape errors"}, bad_shape, 0);
    $display("period %s: high=%0d starts=%0d", tag, high, starts);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t tbl[6];
    int   nt;
    int   snap;
    int   high;
    int   exp_stream[4];

    tbl[0] = '{8'h80, 128};
    tbl[1] = '{8'h40, 64};
    tbl[2] = '{8'h00, 0};
    tbl[3] = '{8'h01, 1};
    tbl[4] = '{8'hFE, 254};
    tbl[5] = '{8'hFF, 255};
    nt = 6;
    exp_stream[0] = 255; exp_stream[1] = 16; exp_stream[2] = 17; exp_stream[3] = 18;

    // Reset values
    #13;
    check("reset pwm_out", int'(a_pwm), 0);
    check("reset period_start", int'(a_ps), 0);
    check("reset underrun", int'(a_ur), 0);
    check("reset sample_ready", int'(a_ready), 1);
    @(posedge clk); #1;
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    // Table-driven periods: each sample is pushed while the previous one plays.
    a_sample_in = tbl[0].sample;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    check("first push accepted", a_acc_cnt, 1);
    check("ready after one push", int'(a_ready), EXP_RDY_ONE);
    a_enable = 1'b1;
    for (int p = 0; p <= nt + 1; p++) begin
      int  eh;
      bit  pe;
      eh = (p == 0) ? 0 : tbl[(p - 1 < nt - 1) ? p - 1 : nt - 1].exp_high;
      pe = (p >= 1) && (p < nt);
      measure(1'b0, 255, eh, pe, pe ? tbl[pe ? p : 0].sample : 8'h00,
              (p == nt + 1) ? 1 : 0, $sformatf("A%0d", p));
    end

    // Clear underrun, then clear coinciding with a fresh underrun
    tick();
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    check("underrun cleared", int'(a_ur), 0);
    repeat (253) tick();
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    check("set beats clear", int'(a_ur), 1);
    check("boundary period_start", int'(a_ps), 1);
    check("duty FF held high", int'(a_pwm), 1);

    // Enable falling
    a_enable = 1'b0;
    tick();
    check("disable pwm_out", int'(a_pwm), 0);
    check("disable period_start", int'(a_ps), 0);
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    repeat (300) tick();
    check("no underrun while idle", int'(a_ur), 0);
    check("idle pwm_out", int'(a_pwm), 0);

    // Streaming source with valid held high
    stream_on = 1'b1;
    stream_data = 8'h10;
    a_sample_in = 8'h10;
    a_valid = 1'b1;
    snap = a_acc_cnt;
    repeat (10) tick();
    check("initial accepts", a_acc_cnt - snap, EXP_FILL);
    check("ready when full", int'(a_ready), 0);
    a_enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      snap = a_acc_cnt;
      measure(1'b0, 255, exp_stream[k], 1'b0, 8'h00, -1, $sformatf("S%0d", k));
      check($sformatf("S%0d accepts", k), a_acc_cnt - snap, (k == 0) ? 0 : 1);
    end

    // Asynchronous reset mid-period with a full buffer
    repeat (5) tick();
    check("pre-reset pwm_out", int'(a_pwm), 1);
    check("pre-reset ready", int'(a_ready), 0);
    stream_on = 1'b0;
    a_valid = 1'b0;
    a_rst_n = 1'b0;
    #2;
    check("async reset pwm_out", int'(a_pwm), 0);
    check("async reset period_start", int'(a_ps), 0);
    check("async reset ready", int'(a_ready), 1);
    @(posedge clk); #1;
    a_rst_n = 1'b1;
    measure(1'b0, 255, 0, 1'b0, 8'h00, 0, "R0");
    measure(1'b0, 255, 0, 1'b0, 8'h00, 1, "R1");

    // PRESCALE = 3
    b_sample_in = 8'h10;
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    check("B ready after push", int'(b_ready), EXP_RDY_ONE);
    b_enable = 1'b1;
    measure(1'b1, 765, 0, 1'b0, 8'h00, 0, "B0");
    measure(1'b1, 765, 48, 1'b0, 8'h00, 0, "B1");
    tick();
    check("B period_start", int'(b_ps), 1);
    check("B underrun", int'(b_ur), 1);
    repeat (19) tick();
    check("B mid-high pwm", int'(b_pwm), 1);
    b_enable = 1'b0;
    tick();
    check("B disable pwm_out", int'(b_pwm), 0);
    repeat (4) tick();
    check("B idle period_start", int'(b_ps), 0);
    b_enable = 1'b1;
    tick();
    check("B re-enable period_start", int'(b_ps), 1);
    check("B re-enable pwm_out", int'(b_pwm), 1);
    high = 0;
    for (int j = 1; j < 765; j++) begin
      tick();
      if (b_pwm) high++;
      if (b_ps) check("B stray period_start", j, 765);
    end
    check("B re-enable high rest", high, 47);
    tick();
    check("B next period_start", int'(b_ps), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
